// File: rtl/reg4_ctrl_pkg.sv
// Shared types for the 4-bit register-bank transfer sequencer: op codes,
// FSM states, default widths and the command record.
package reg4_ctrl_pkg;

  localparam int DEF_NREG   = 4;
  localparam int DEF_W      = 4;
  localparam int DEF_IDX_W  = 2;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_MOV = 2'd1,
    OP_LDI = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Command record at the default widths.
  typedef struct packed {
    op_e                  op;
    logic [DEF_IDX_W-1:0] src;
    logic [DEF_IDX_W-1:0] dst;
    logic [DEF_W-1:0]     imm;
  } cmd_t;

  // Flattened width of a command record for a given index/data width.
  function automatic int cmd_width(input int idx_w, input int w);
    return 2 + 2 * idx_w + w;
  endfunction

endpackage

// File: rtl/reg4_cmd_fifo.sv
// Two-entry command buffer placed in front of the transfer FSM when
// REG4_XFER_CMDBUF_EN is defined. Push is ignored when full, pop when empty.
module reg4_cmd_fifo
  import reg4_ctrl_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the buffer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: entry storage has no reset; emptiness is tracked by count, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/reg4_xfer_ctrl.sv
// Transfer sequencer for a bank of NREG registers sharing one data bus.
// Each MOV/LDI runs DRIVE (source on) -> LATCH (source on, dst inen) -> DONE,
// so the bus has exactly one driver whenever a destination latches.
// Optional build macro: REG4_XFER_CMDBUF_EN adds a 2-entry command buffer
// so transfers chain DRIVE->LATCH->DONE->DRIVE without an IDLE gap.
module reg4_xfer_ctrl
  import reg4_ctrl_pkg::*;
#(
  parameter int NREG  = DEF_NREG,
  parameter int W     = DEF_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_src,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic [W-1:0]     cmd_imm,
  output logic [NREG-1:0]  oen,
  output logic [NREG-1:0]  inen,
  output logic             imm_oen,
  output logic [W-1:0]     imm_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef struct packed {
    op_e              op;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
    logic [W-1:0]     imm;
  } xfer_t;

  localparam logic [IDX_W:0]  NREG_V = (IDX_W + 1)'(NREG);
  localparam logic [NREG-1:0] ONE    = {{(NREG - 1){1'b0}}, 1'b1};

  state_e state;
  state_e state_nx;
  xfer_t  in_cmd;     // command presented to the FSM
  logic   in_valid;
  logic   fsm_ready;  // FSM can take a command this cycle
  logic   take;
  logic   in_rej;
  logic   in_xfer;
  xfer_t  cur;        // command being sequenced
  logic   rej_q;

  assign fsm_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign take      = in_valid & fsm_ready;

`ifdef REG4_XFER_CMDBUF_EN
  localparam int CW = cmd_width(IDX_W, W);

  logic [CW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  reg4_cmd_fifo #(.DW(CW)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (cmd_valid & cmd_ready),
    .din   ({cmd_op, cmd_src, cmd_dst, cmd_imm}),
    .pop   (take),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_cmd    = xfer_t'(fifo_dout);
  assign in_valid  = ~fifo_empty;
  assign cmd_ready = clr & ~fifo_full;
`else
  assign in_cmd    = '{op: op_e'(cmd_op), src: cmd_src, dst: cmd_dst, imm: cmd_imm};
  assign in_valid  = cmd_valid;
  assign cmd_ready = clr & fsm_ready;
`endif

  // Classify the incoming command: rejected, a real bus transfer, or a no-op.
  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    in_rej  = 1'b0;
    in_xfer = 1'b0;
    case (in_cmd.op)
      OP_NOP: ;
      OP_MOV: begin
        if (({1'b0, in_cmd.src} >= NREG_V) || ({1'b0, in_cmd.dst} >= NREG_V)) in_rej = 1'b1;
        else if (in_cmd.src != in_cmd.dst)                                      in_xfer = 1'b1;
      end
      OP_LDI: begin
        if ({1'b0, in_cmd.dst} >= NREG_V) in_rej  = 1'b1;
        else                              in_xfer = 1'b1;
      end
      default: in_rej = 1'b1;
    endcase
  end

  // Next-state logic; short-circuit and rejected commands go straight to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (take) state_nx = in_xfer ? ST_DRIVE : ST_DONE;
        else      state_nx = ST_IDLE;
      end
      ST_DRIVE: state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register and command capture on accept; reset discards any in-flight command.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
      cur   <= '0;
      rej_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        cur   <= in_cmd;
        rej_q <= in_rej;
      end
    end
  end

  // Strobe decode: the source stays on through DRIVE and LATCH, inen only in LATCH.
  always_comb begin
    oen      = '0;
    inen     = '0;
    imm_oen  = 1'b0;
    imm_data = '0;
    if ((state == ST_DRIVE) || (state == ST_LATCH)) begin
      if (cur.op == OP_LDI) begin
        imm_oen  = 1'b1;
        imm_data = cur.imm;
      end else begin
        oen = ONE << cur.src;
      end
    end
    if (state == ST_LATCH) inen = ONE << cur.dst;
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign err  = done & rej_q;

endmodule

// File: tb/tb_reg4_xfer_ctrl.sv
// Scoreboard bench for reg4_xfer_ctrl: stimulus pushes the expected transfer
// profile per command; a negedge monitor accumulates the strobes it sees and
// compares when done pulses. A second NREG=3 instance covers index rejects.
module tb_reg4_xfer_ctrl;
  import reg4_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_src = 2'd0;
  logic [1:0] cmd_dst = 2'd0;
  logic [3:0] cmd_imm = 4'd0;
  logic [3:0] oen;
  logic [3:0] inen;
  logic       imm_oen;
  logic [3:0] imm_data;
  logic       busy;
  logic       done;
  logic       err;

  logic       c3_valid = 1'b0;
  logic       c3_ready;
  logic [1:0] c3_op = 2'd0;
  logic [1:0] c3_src = 2'd0;
  logic [1:0] c3_dst = 2'd0;
  logic [3:0] c3_imm = 4'd0;
  logic [2:0] c3_oen;
  logic [2:0] c3_inen;
  logic       c3_imm_oen;
  logic [3:0] c3_imm_data;
  logic       c3_busy;
  logic       c3_done;
  logic       c3_err;

  always #5 clk = ~clk;

  reg4_xfer_ctrl #(.NREG(4), .W(4), .IDX_W(2)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .oen(oen), .inen(inen), .imm_oen(imm_oen), .imm_data(imm_data),
    .busy(busy), .done(done), .err(err)
  );

  reg4_xfer_ctrl #(.NREG(3), .W(4), .IDX_W(2)) dut3 (
    .clk(clk), .clr(clr), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_src(c3_src), .cmd_dst(c3_dst), .cmd_imm(c3_imm),
    .oen(c3_oen), .inen(c3_inen), .imm_oen(c3_imm_oen), .imm_data(c3_imm_data),
    .busy(c3_busy), .done(c3_done), .err(c3_err)
  );

  typedef struct {
    logic       err;
    int         lat;
    logic [3:0] oen_or;
    int         oen_n;
    logic [3:0] inen_or;
    int         inen_n;
    int         inen_cyc;
    int         imm_n;
    logic [3:0] imm_val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t exp_mov(input logic [3:0] o, input logic [3:0] i);
    exp_t e = '{err: 1'b0, lat: 3, oen_or: o, oen_n: 2, inen_or: i, inen_n: 1,
                inen_cyc: 2, imm_n: 0, imm_val: 4'h0};
    return e;
  endfunction

  function automatic exp_t exp_ldi(input logic [3:0] i, input logic [3:0] v);
    exp_t e = '{err: 1'b0, lat: 3, oen_or: 4'h0, oen_n: 0, inen_or: i, inen_n: 1,
                inen_cyc: 2, imm_n: 2, imm_val: v};
    return e;
  endfunction

  function automatic exp_t exp_short(input logic e_err);
    exp_t e = '{err: e_err, lat: 1, oen_or: 4'h0, oen_n: 0, inen_or: 4'h0, inen_n: 0,
                inen_cyc: 0, imm_n: 0, imm_val: 4'h0};
    return e;
  endfunction

  // Monitor state
  bit         inflight = 1'b0;
  int         cyc;
  logic [3:0] a_oen_or, a_inen_or, a_imm;
  int         a_oen_n, a_inen_n, a_inen_cyc, a_imm_n;

  // Monitor: invariants every cycle, per-command profile compared at done.
  always @(negedge clk) begin
    if (!clr) begin
      inflight = 1'b0;
      sb.delete();
    end else begin
      check("inv_one_source", 32'(($countones(oen) + 32'(imm_oen)) <= 1), 32'd1);
      check("inv_one_inen", 32'($countones(inen) <= 1), 32'd1);
      if (inen != 4'h0) check("inv_inen_has_src", 32'((oen != 4'h0) || imm_oen), 32'd1);
      if (busy && !done) check("holdoff_ready", 32'(cmd_ready), 32'd0);
      if (err) check("err_with_done", 32'(done), 32'd1);
      if (inflight) begin
        cyc++;
        if (oen != 4'h0) begin a_oen_or |= oen; a_oen_n++; end
        if (inen != 4'h0) begin a_inen_or |= inen; a_inen_n++; a_inen_cyc = cyc; end
        if (imm_oen) begin a_imm_n++; a_imm = imm_data; end
        if (done) begin
          inflight = 1'b0;
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty: done with no expected entry at %0t", $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("err", 32'(err), 32'(e.err));
            check("latency", 32'(cyc), 32'(e.lat));
            check("oen_mask", 32'(a_oen_or), 32'(e.oen_or));
            check("oen_cycles", 32'(a_oen_n), 32'(e.oen_n));
            check("inen_mask", 32'(a_inen_or), 32'(e.inen_or));
            check("inen_cycles", 32'(a_inen_n), 32'(e.inen_n));
            if (e.inen_n > 0) check("inen_phase", 32'(a_inen_cyc), 32'(e.inen_cyc));
            check("imm_cycles", 32'(a_imm_n), 32'(e.imm_n));
            if (e.imm_n > 0) check("imm_data", 32'(a_imm), 32'(e.imm_val));
          end
        end else if (cyc > 8) begin
          inflight = 1'b0;
          n_cmp++; n_bad++;
          $display("FAIL done_timeout: no done after %0d cycles", cyc);
          if (sb.size() != 0) void'(sb.pop_front());
        end
      end else if (done) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_done: done=1 with nothing accepted at %0t", $time);
      end
      if (cmd_valid && cmd_ready) begin
        inflight   = 1'b1;
        cyc        = 0;
        a_oen_or   = 4'h0;
        a_inen_or  = 4'h0;
        a_imm      = 4'h0;
        a_oen_n    = 0;
        a_inen_n   = 0;
        a_inen_cyc = 0;
        a_imm_n    = 0;
      end
    end
  end

  // Issue one command, waiting (bounded) for accept; returns cycles held off.
  task automatic send(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                      input logic [3:0] imm, input exp_t e, output int waited);
    bit ok = 1'b0;
    sb.push_back(e);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
    cmd_valid = 1'b1;
    waited = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: command never accepted");
    end
    cmd_valid = 1'b0;
    // Garbage on the idle fields must be ignored.
    cmd_op  = 2'd3;
    cmd_src = 2'($urandom);
    cmd_dst = 2'($urandom);
    cmd_imm = 4'($urandom);
  endtask

  // One command into the NREG=3 instance; report done/err one cycle after accept.
  task automatic send3(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       output logic d, output logic e, output logic [2:0] en);
    bit ok = 1'b0;
    c3_op = op; c3_src = src; c3_dst = dst; c3_imm = 4'h7;
    c3_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (c3_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send3_timeout: command never accepted");
    end
    c3_valid = 1'b0;
    @(negedge clk);
    d  = c3_done;
    e  = c3_err;
    en = c3_oen | c3_inen;
  endtask

  initial begin
    int         w;
    logic       d3, e3;
    logic [2:0] en3;

    #1 clr = 1'b0;
    #3;
    check("rst_oen", 32'(oen), 32'd0);
    check("rst_inen", 32'(inen), 32'd0);
    check("rst_imm_oen", 32'(imm_oen), 32'd0);
    check("rst_imm_data", 32'(imm_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    #1 check("idle_ready", 32'(cmd_ready), 32'd1);

    // Directed vectors: {op, src, dst, imm} and hand-derived profile / hold-off.
    send(OP_MOV, 2'd1, 2'd3, 4'h0, exp_mov(4'b0010, 4'b1000), w);
    check("wait_first", 32'(w), 32'd0);
    send(OP_LDI, 2'd0, 2'd0, 4'hA, exp_ldi(4'b0001, 4'hA), w);
    check("wait_after_mov", 32'(w), 32'd2);
    send(OP_MOV, 2'd2, 2'd2, 4'h0, exp_short(1'b0), w);
    check("wait_after_ldi", 32'(w), 32'd2);
    send(OP_RSV, 2'd0, 2'd1, 4'h0, exp_short(1'b1), w);
    check("wait_after_short", 32'(w), 32'd0);
    send(OP_NOP, 2'd3, 2'd1, 4'h0, exp_short(1'b0), w);
    check("wait_after_rej", 32'(w), 32'd0);
    send(OP_MOV, 2'd3, 2'd0, 4'h0, exp_mov(4'b1000, 4'b0001), w);
    check("wait_after_nop", 32'(w), 32'd0);
    send(OP_LDI, 2'd1, 2'd2, 4'h5, exp_ldi(4'b0100, 4'h5), w);
    check("wait_ldi2", 32'(w), 32'd2);
    send(OP_MOV, 2'd0, 2'd1, 4'h0, exp_mov(4'b0001, 4'b0010), w);
    check("wait_mov3", 32'(w), 32'd2);
    repeat (6) @(posedge clk);
    #1;

    // Asynchronous reset in LATCH: strobes drop without a clock edge.
    send(OP_MOV, 2'd2, 2'd1, 4'h0, exp_mov(4'b0100, 4'b0010), w);
    @(posedge clk);
    #2;
    check("pre_rst_oen", 32'(oen), 32'b0100);
    check("pre_rst_inen", 32'(inen), 32'b0010);
    clr = 1'b0;
    #1;
    check("mid_rst_oen", 32'(oen), 32'd0);
    check("mid_rst_inen", 32'(inen), 32'd0);
    check("mid_rst_imm_oen", 32'(imm_oen), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    send(OP_LDI, 2'd0, 2'd3, 4'hF, exp_ldi(4'b1000, 4'hF), w);
    check("wait_post_rst", 32'(w), 32'd0);

    // NREG=3 instance: out-of-range indices are rejected, in-range ones are not.
    send3(OP_LDI, 2'd0, 2'd3, d3, e3, en3);
    check("n3_ldi_dst3_done", 32'(d3), 32'd1);
    check("n3_ldi_dst3_err", 32'(e3), 32'd1);
    check("n3_ldi_dst3_en", 32'(en3), 32'd0);
    send3(OP_MOV, 2'd3, 2'd0, d3, e3, en3);
    check("n3_mov_src3_err", 32'(e3), 32'd1);
    send3(OP_MOV, 2'd2, 2'd0, d3, e3, en3);
    check("n3_mov_ok_done", 32'(d3), 32'd0);
    check("n3_mov_ok_oen", 32'(en3), 32'b100);

    // Drain the scoreboard (bounded).
    for (int i = 0; i < 50 && (sb.size() != 0 || inflight); i++) @(negedge clk);
    if (sb.size() != 0 || inflight) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected responses never seen", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
